// File: rtl/mfp_7sd_marquee_ctrl.sv
// mfp_7sd_marquee_ctrl
// Scrolling-message sequencer for the 8-digit seven-segment driver. A message
// buffer is written by software. A scroll steps an 8-character window across
// the message followed by an 8-blank gap. All digits update together at the
// end of each window fill.
module mfp_7sd_marquee_ctrl #(
  parameter int         MSG_DEPTH  = 32,
  parameter int         ADDR_W     = 5,
  parameter int         STEP_DIV   = 25_000_000,
  parameter logic [4:0] BLANK_CODE = 5'h1F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              start,
  input  logic              stop,
  output logic [7:0]        EN,
  output logic [63:0]       DIGITS,
  output logic [7:0]        DP,
  output logic              busy,
  output logic              wrap
);

  localparam int PW = ADDR_W + 2;
  localparam int SW = $clog2(STEP_DIV);
  localparam logic [SW-1:0]   STEP_LAST   = SW'(STEP_DIV - 1);
  localparam logic [ADDR_W:0] DEPTH_LEN   = (ADDR_W+1)'(MSG_DEPTH);
  localparam logic [63:0]     BLANK_DIGITS = {8{3'b000, BLANK_CODE}};

  typedef enum logic [1:0] {IDLE, FILL, SHOW} state_t;

  // Buffer entries hold {dp, code}; bits [6:5] of the write data are dropped.
  logic [5:0]        mem [MSG_DEPTH];
  logic [5:0]        rdData_q;
  logic              rdBlank_q;

  state_t            state_q;
  logic [ADDR_W:0]   len_q;
  logic [PW-1:0]     ptr_q;
  logic [3:0]        fillCnt_q;
  logic [SW-1:0]     stepCnt_q;
  logic [5:0]        shadow_q [7];
  logic [7:0]        en_q;
  logic [7:0]        dp_q;
  logic [63:0]       digits_q;
  logic              wrap_q;

  logic              unusedWrBits;
  logic [ADDR_W:0]   lenClamp_d;
  logic              startOk_d;
  logic [PW-1:0]     period_d;
  logic [PW-1:0]     sum_d;
  logic [PW-1:0]     idx_d;
  logic [ADDR_W-1:0] rdAddr_d;
  logic              rdBlank_d;
  logic [PW-1:0]     ptrNext_d;
  logic              ptrWraps_d;
  logic [5:0]        fillData_d;

  assign unusedWrBits = ^wr_data[6:5];

  // Start qualification, length clamp and the modulo window address.
  // ptr+j never exceeds 2*P, so one conditional subtract replaces a divider.
  always_comb begin
    lenClamp_d = (msg_len > DEPTH_LEN) ? DEPTH_LEN : msg_len;
    startOk_d  = start && !stop && (msg_len != '0);
    period_d   = PW'(len_q) + PW'(8);
    sum_d      = ptr_q + PW'(fillCnt_q[2:0]);
    idx_d      = (sum_d >= period_d) ? (sum_d - period_d) : sum_d;
    rdAddr_d   = idx_d[ADDR_W-1:0];
    rdBlank_d  = (idx_d >= PW'(len_q));
    ptrNext_d  = ptr_q + PW'(1);
    ptrWraps_d = (ptrNext_d == period_d);
    fillData_d = rdBlank_q ? {1'b0, BLANK_CODE} : rdData_q;
  end

  // Message RAM with one registered read port; a same-address write and read
  // in one cycle return the old contents. Not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_data[7], wr_data[4:0]};
    end
    rdData_q  <= mem[rdAddr_d];
    rdBlank_q <= rdBlank_d;
  end

  // Scroll FSM: stop beats start, start (re)launches a fill, FILL gathers
  // eight characters then publishes them at once, SHOW waits for the step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      ptr_q     <= '0;
      fillCnt_q <= '0;
      stepCnt_q <= '0;
      en_q      <= '0;
      dp_q      <= '0;
      digits_q  <= BLANK_DIGITS;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (stop) begin
        state_q   <= IDLE;
        ptr_q     <= '0;
        fillCnt_q <= '0;
        stepCnt_q <= '0;
        en_q      <= '0;
        dp_q      <= '0;
        digits_q  <= BLANK_DIGITS;
      end else if (startOk_d) begin
        state_q   <= FILL;
        len_q     <= lenClamp_d;
        ptr_q     <= '0;
        fillCnt_q <= '0;
        stepCnt_q <= '0;
      end else begin
        case (state_q)
          FILL: begin
            stepCnt_q <= stepCnt_q + SW'(1);
            fillCnt_q <= fillCnt_q + 4'd1;
            if (fillCnt_q != 4'd0 && fillCnt_q != 4'd8) begin
              shadow_q[fillCnt_q[2:0] - 3'd1] <= fillData_d;
            end
            if (fillCnt_q == 4'd8) begin
              for (int j = 0; j < 7; j++) begin
                digits_q[8*(7-j) +: 8] <= {3'b000, shadow_q[j][4:0]};
                dp_q[7-j]              <= shadow_q[j][5];
              end
              digits_q[7:0] <= {3'b000, fillData_d[4:0]};
              dp_q[0]       <= fillData_d[5];
              en_q          <= 8'hFF;
              state_q       <= SHOW;
            end
          end
          SHOW: begin
            if (stepCnt_q == STEP_LAST) begin
              stepCnt_q <= '0;
              fillCnt_q <= '0;
              ptr_q     <= ptrWraps_d ? '0 : ptrNext_d;
              wrap_q    <= ptrWraps_d;
              state_q   <= FILL;
            end else begin
              stepCnt_q <= stepCnt_q + SW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign EN     = en_q;
  assign DIGITS = digits_q;
  assign DP     = dp_q;
  assign busy   = (state_q != IDLE);
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_mfp_7sd_marquee_ctrl.sv
// tb_mfp_7sd_marquee_ctrl
// Self-checking bench for the marquee sequencer with a short step period.
// Expected windows come from a behavioural model of the message buffer and
// are queued when a scroll is launched, then popped when the DUT publishes.
module tb_mfp_7sd_marquee_ctrl;

  localparam int          STEP      = 16;
  localparam logic [63:0] ALL_BLANK = {8{8'h1F}};

  typedef struct {
    logic [63:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  msg_len;
  logic        start;
  logic        stop;
  logic [7:0]  EN;
  logic [63:0] DIGITS;
  logic [7:0]  DP;
  logic        busy;
  logic        wrap;

  logic [5:0]  tbMem [32];
  exp_t        sbQ [$];
  int          checkCount = 0;
  int          passCount  = 0;

  mfp_7sd_marquee_ctrl #(
    .MSG_DEPTH(32), .ADDR_W(5), .STEP_DIV(STEP), .BLANK_CODE(5'h1F)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .msg_len(msg_len), .start(start), .stop(stop),
    .EN(EN), .DIGITS(DIGITS), .DP(DP), .busy(busy), .wrap(wrap)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Reference window: digit 7-j shows S[(ptr+j) mod (len+8)].
  function automatic exp_t modelWindow(input int ptr, input int len);
    exp_t e;
    int   idx;
    e.en = 8'hFF;
    e.digits = '0;
    e.dp = '0;
    for (int j = 0; j < 8; j++) begin
      idx = (ptr + j) % (len + 8);
      if (idx < len) begin
        e.digits[8*(7-j) +: 8] = {3'b000, tbMem[idx][4:0]};
        e.dp[7-j] = tbMem[idx][5];
      end else begin
        e.digits[8*(7-j) +: 8] = 8'h1F;
      end
    end
    return e;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Writes one entry; junk in bits [6:5] must be ignored by the DUT.
  task automatic writeBuf(input int addr, input logic [4:0] code, input logic dp);
    wr_en   = 1'b1;
    wr_addr = 5'(addr);
    wr_data = {dp, 2'b11, code};
    tbMem[addr] = {dp, code};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge right after the edge that samples start.
  task automatic doStart(input int len);
    start   = 1'b1;
    msg_len = 6'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = '0; start = 1'b0; stop = 1'b0;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(1);
    checkCount++;
    if (EN !== 8'h00) $display("[TB] FAIL reset_en got %h want 00", EN);
    else passCount++;
    checkCount++;
    if (DIGITS !== ALL_BLANK) $display("[TB] FAIL reset_digits got %h want %h", DIGITS, ALL_BLANK);
    else passCount++;
    checkCount++;
    if (DP !== 8'h00 || busy !== 1'b0 || wrap !== 1'b0)
      $display("[TB] FAIL reset_misc dp=%h busy=%b wrap=%b want 00/0/0", DP, busy, wrap);
    else passCount++;
  endtask

  task automatic test_basic;
    exp_t e;
    for (int i = 0; i < 8; i++) writeBuf(i, 5'(i), (i == 3));
    sbQ.push_back(modelWindow(0, 8));
    doStart(8);
    waitCycles(8);
    checkCount++;
    if (EN !== 8'h00 || busy !== 1'b1)
      $display("[TB] FAIL basic_early en=%h busy=%b want 00/1", EN, busy);
    else passCount++;
    waitCycles(1);
    checkCount++;
    if (DIGITS !== 64'h00_01_02_03_04_05_06_07 || DP !== 8'h10 || EN !== 8'hFF)
      $display("[TB] FAIL basic_const got %h/%h/%h want 0001020304050607/10/ff", DIGITS, DP, EN);
    else passCount++;
    checkCount++;
    if (sbQ.size() == 0) $display("[TB] FAIL basic_sb queue empty");
    else begin
      e = sbQ.pop_front();
      if (DIGITS !== e.digits || DP !== e.dp || EN !== e.en)
        $display("[TB] FAIL basic_sb got %h/%h/%h want %h/%h/%h", DIGITS, DP, EN, e.digits, e.dp, e.en);
      else passCount++;
    end
  endtask

  task automatic test_scroll;
    exp_t e;
    int   wraps = 0;
    for (int n = 0; n <= 16; n++) sbQ.push_back(modelWindow(n % 16, 8));
    doStart(8);
    for (int c = 1; c <= 16*STEP + 9; c++) begin
      @(negedge clk);
      if (wrap === 1'b1) wraps++;
      if (c == 16*STEP) begin
        checkCount++;
        if (wrap !== 1'b1) $display("[TB] FAIL scroll_wrap_time got %b want 1", wrap);
        else passCount++;
      end
      if (c == 8*STEP + 9) begin
        checkCount++;
        if (DIGITS !== ALL_BLANK || DP !== 8'h00)
          $display("[TB] FAIL scroll_gap got %h/%h want %h/00", DIGITS, DP, ALL_BLANK);
        else passCount++;
      end
      if (c >= 9 && (c - 9) % STEP == 0) begin
        checkCount++;
        if (sbQ.size() == 0) $display("[TB] FAIL scroll_sb queue empty at c=%0d", c);
        else begin
          e = sbQ.pop_front();
          if (DIGITS !== e.digits || DP !== e.dp || EN !== e.en)
            $display("[TB] FAIL scroll_sb c=%0d got %h/%h/%h want %h/%h/%h",
                     c, DIGITS, DP, EN, e.digits, e.dp, e.en);
          else passCount++;
        end
      end
    end
    checkCount++;
    if (wraps != 1) $display("[TB] FAIL scroll_wrap_count got %0d want 1", wraps);
    else passCount++;
  endtask

  task automatic test_short;
    exp_t e;
    writeBuf(0, 5'hA, 1'b0);
    writeBuf(1, 5'hB, 1'b0);
    writeBuf(2, 5'hC, 1'b0);
    sbQ.push_back(modelWindow(9, 3));
    doStart(3);
    waitCycles(9*STEP + 9);
    checkCount++;
    if (DIGITS !== 64'h1F_1F_0A_0B_0C_1F_1F_1F)
      $display("[TB] FAIL short_const got %h want 1f1f0a0b0c1f1f1f", DIGITS);
    else passCount++;
    checkCount++;
    if (sbQ.size() == 0) $display("[TB] FAIL short_sb queue empty");
    else begin
      e = sbQ.pop_front();
      if (DIGITS !== e.digits || DP !== e.dp || EN !== e.en)
        $display("[TB] FAIL short_sb got %h/%h/%h want %h/%h/%h", DIGITS, DP, EN, e.digits, e.dp, e.en);
      else passCount++;
    end
  endtask

  task automatic test_stop;
    start = 1'b1; stop = 1'b1; msg_len = 6'd3;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checkCount++;
    if (busy !== 1'b0 || EN !== 8'h00 || DIGITS !== ALL_BLANK || DP !== 8'h00)
      $display("[TB] FAIL stop_blank busy=%b en=%h dig=%h dp=%h want 0/00/%h/00", busy, EN, DIGITS, DP, ALL_BLANK);
    else passCount++;
    doStart(0);
    waitCycles(12);
    checkCount++;
    if (busy !== 1'b0 || EN !== 8'h00)
      $display("[TB] FAIL stop_zero_len busy=%b en=%h want 0/00", busy, EN);
    else passCount++;
  endtask

  task automatic test_clamp_write;
    exp_t       e;
    logic [7:0] oldD2;
    int         wraps = 0;
    for (int i = 0; i < 32; i++) writeBuf(i, 5'((i*7 + 3) % 31), i[0]);
    sbQ.push_back(modelWindow(0, 32));
    doStart(40);
    waitCycles(9);
    checkCount++;
    if (sbQ.size() == 0) $display("[TB] FAIL clamp_sb0 queue empty");
    else begin
      e = sbQ.pop_front();
      if (DIGITS !== e.digits || DP !== e.dp || EN !== e.en)
        $display("[TB] FAIL clamp_sb0 got %h/%h want %h/%h", DIGITS, DP, e.digits, e.dp);
      else passCount++;
    end
    oldD2 = {3'b000, tbMem[5][4:0]};
    writeBuf(5, 5'h1E, 1'b1);
    sbQ.push_back(modelWindow(1, 32));
    sbQ.push_back(modelWindow(32, 32));
    sbQ.push_back(modelWindow(0, 32));
    for (int c = 11; c <= 40*STEP + 9; c++) begin
      @(negedge clk);
      if (wrap === 1'b1) wraps++;
      if (c == 24) begin
        checkCount++;
        if (DIGITS[23:16] !== oldD2) $display("[TB] FAIL clamp_hold got %h want %h", DIGITS[23:16], oldD2);
        else passCount++;
      end
      if (c == 40*STEP + 9) begin
        checkCount++;
        if (DIGITS[23:16] !== 8'h1E || DP[2] !== 1'b1)
          $display("[TB] FAIL clamp_newdata got %h/%b want 1e/1", DIGITS[23:16], DP[2]);
        else passCount++;
      end
      if (c == STEP + 9 || c == 32*STEP + 9 || c == 40*STEP + 9) begin
        checkCount++;
        if (sbQ.size() == 0) $display("[TB] FAIL clamp_sb queue empty at c=%0d", c);
        else begin
          e = sbQ.pop_front();
          if (DIGITS !== e.digits || DP !== e.dp || EN !== e.en)
            $display("[TB] FAIL clamp_sb c=%0d got %h/%h want %h/%h", c, DIGITS, DP, e.digits, e.dp);
          else passCount++;
        end
      end
    end
    checkCount++;
    if (wraps != 1) $display("[TB] FAIL clamp_wrap_count got %0d want 1", wraps);
    else passCount++;
  endtask

  task automatic test_reset_mid_fill;
    int bad = 0;
    doStart(8);
    waitCycles(4);
    checkCount++;
    if (EN !== 8'hFF) $display("[TB] FAIL midfill_hold got %h want ff", EN);
    else passCount++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkCount++;
    if (EN !== 8'h00 || DIGITS !== ALL_BLANK || DP !== 8'h00 || busy !== 1'b0 || wrap !== 1'b0)
      $display("[TB] FAIL midfill_reset en=%h dig=%h dp=%h busy=%b wrap=%b", EN, DIGITS, DP, busy, wrap);
    else passCount++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wrap !== 1'b0 || EN !== 8'h00) bad++;
    end
    checkCount++;
    if (bad != 0) $display("[TB] FAIL midfill_quiet got %0d bad cycles want 0", bad);
    else passCount++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    doStart(8);
    waitCycles(2);
    sbQ.push_back(modelWindow(0, 5));
    doStart(5);
    waitCycles(8);
    checkCount++;
    if (EN !== 8'h00) $display("[TB] FAIL b2b_abandon got %h want 00", EN);
    else passCount++;
    waitCycles(1);
    checkCount++;
    if (sbQ.size() == 0) $display("[TB] FAIL b2b_sb queue empty");
    else begin
      e = sbQ.pop_front();
      if (DIGITS !== e.digits || DP !== e.dp || EN !== e.en)
        $display("[TB] FAIL b2b_sb got %h/%h/%h want %h/%h/%h", DIGITS, DP, EN, e.digits, e.dp, e.en);
      else passCount++;
    end
  endtask

  // Test sequence.
  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_scroll;
    test_short;
    test_stop;
    test_clamp_write;
    test_reset_mid_fill;
    test_back_to_back;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
